// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Load/store unit for the memory stage. It takes the execute-stage ALU result
// as an effective address (loads/stores) or as a pass-through writeback value
// (all other ops). It drives a single-outstanding-request data-memory port,
// lane-aligns store data and byte strobes, and extracts and sign/zero-extends
// load data. Every accepted op produces exactly one writeback beat.
//
// Configuration macro:
//   LSU_MISALIGN_CHECK_EN - when defined, a memory op whose address is not a
//                           multiple of its access size skips the memory port,
//                           writes back with wb_rd_wen = 0 and pulses
//                           misalign_err. When undefined, misalign_err is tied
//                           low and misaligned accesses are issued as-is.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ex_valid / ex_ready  op handshake from the execute stage
//   alu_output           effective address (memory ops) or result value
//   is_load, is_store    op kind (never both)
//   mem_size             0 = byte, 1 = half, 2 = word, 3 = dword
//   mem_unsigned         zero-extend load data instead of sign-extending
//   store_data           right-justified store value
//   rd_addr, rd_wen      destination register index / write enable
//   mem_req .. mem_wstrb data-memory request (held stable until mem_ack)
//   mem_ack, mem_rdata   request completion and read data
//   wb_valid .. wb_data  single-cycle writeback beat
//   misalign_err         misaligned-access pulse, coincident with wb_valid
// -----------------------------------------------------------------------------
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [63:0] alu_output,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [63:0] store_data,
    input  logic [4:0]  rd_addr,
    input  logic        rd_wen,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_rd_wen,
    output logic [63:0] wb_data,
    output logic        misalign_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;

    // Registered copy of the accepted op.
    logic [63:0] addr_q;
    logic [63:0] sdata_q;
    logic [63:0] wb_data_q;
    logic        is_load_q;
    logic        is_store_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [4:0]  rd_q;
    logic        rd_wen_q;
    logic        misalign_q;

    logic        is_mem;
    logic        misaligned_in;
    logic [2:0]  off;
    logic [5:0]  shamt;
    logic [7:0]  base_mask;
    logic [63:0] raw;
    logic [63:0] load_ext;

    assign is_mem = is_load | is_store;

    // Alignment check on the incoming address, evaluated at accept time so a
    // misaligned op can bypass the memory port entirely.
`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        misaligned_in = 1'b0;
        case (mem_size)
            2'd0:    misaligned_in = 1'b0;
            2'd1:    misaligned_in = alu_output[0];
            2'd2:    misaligned_in = |alu_output[1:0];
            default: misaligned_in = |alu_output[2:0];
        endcase
    end
`else
    assign misaligned_in = 1'b0;
`endif

    // Byte offset inside the addressed dword and the matching bit shift.
    assign off   = addr_q[2:0];
    assign shamt = {off, 3'b000};

    always_comb begin
        base_mask = 8'h01;
        case (size_q)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    // Load extraction: bring the addressed byte to lane 0, keep the access
    // width, then extend from its top bit. Bytes beyond lane 7 shift in as 0.
    assign raw = mem_rdata >> shamt;

    always_comb begin
        load_ext = raw;
        case (size_q)
            2'd0:    load_ext = unsigned_q ? {56'd0, raw[7:0]}
                                           : {{56{raw[7]}}, raw[7:0]};
            2'd1:    load_ext = unsigned_q ? {48'd0, raw[15:0]}
                                           : {{48{raw[15]}}, raw[15:0]};
            2'd2:    load_ext = unsigned_q ? {32'd0, raw[31:0]}
                                           : {{32{raw[31]}}, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

    // Next-state logic. ex_ready is only high in IDLE, so ex_valid there is
    // an accept.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ex_valid) begin
                    state_next = (is_mem && !misaligned_in) ? ST_REQ : ST_RESP;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            sdata_q    <= '0;
            wb_data_q  <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'd0;
            rd_q       <= 5'd0;
            rd_wen_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state <= state_next;

            if (state == ST_IDLE && ex_valid) begin
                addr_q     <= alu_output;
                sdata_q    <= store_data;
                is_load_q  <= is_load;
                is_store_q <= is_store;
                unsigned_q <= mem_unsigned;
                size_q     <= mem_size;
                rd_q       <= rd_addr;
                rd_wen_q   <= rd_wen;
                misalign_q <= is_mem && misaligned_in;
                // Pass-through value for non-memory ops; loads overwrite it.
                wb_data_q  <= alu_output;
            end

            // mem_ack outside REQ is ignored because only REQ looks at it.
            if (state == ST_REQ && mem_ack && is_load_q) begin
                wb_data_q <= load_ext;
            end
        end
    end

    // Gated by rst so ex_ready stays low while reset is held.
    assign ex_ready     = (state == ST_IDLE) && !rst;

    assign mem_req      = (state == ST_REQ);
    assign mem_we       = mem_req && is_store_q;
    assign mem_addr     = {addr_q[63:3], 3'b000};
    // Truncating shifts drop strobe/data bits pushed past lane 7.
    assign mem_wdata    = is_store_q ? (sdata_q << shamt) : 64'd0;
    assign mem_wstrb    = is_store_q ? (base_mask << off) : 8'h00;

    assign wb_valid     = (state == ST_RESP);
    assign wb_rd_addr   = rd_q;
    assign wb_rd_wen    = rd_wen_q && !misalign_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = (state == ST_RESP) && misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
//
// Self-checking bench for mem_stage_lsu. A transaction-level model predicts,
// from each op's accept cycle and its memory wait, which cycles carry a
// request or a writeback and what their values must be. Inputs are driven
// 1 time unit after the rising edge; outputs are compared on the falling edge.
// Directed ops pin the model with literal values; randomized ops (including
// spurious acks and occasional resets) are checked against it.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [63:0] alu_output = '0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic        mem_unsigned = 1'b0;
    logic [63:0] store_data = '0;
    logic [4:0]  rd_addr = 5'd0;
    logic        rd_wen = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_wen;
    logic [63:0] wb_data;
    logic        misalign_err;

    mem_stage_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .alu_output   (alu_output),
        .is_load      (is_load),
        .is_store     (is_store),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .store_data   (store_data),
        .rd_addr      (rd_addr),
        .rd_wen       (rd_wen),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_wen    (wb_rd_wen),
        .wb_data      (wb_data),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] rdata;
        logic        mis;
        int          w;     // REQ cycles up to and including the ack cycle
    } op_t;

    int   checks = 0;
    int   failures = 0;

    // Model state.
    int   cyc = 0;
    int   acc_cyc = 0;
    int   wb_cyc_exp = 0;
    bit   inflight = 1'b0;
    bit   prev_rst = 1'b0;
    bit   rst_drive = 1'b1;
    bit   rand_mode = 1'b0;
    bit   offer_valid = 1'b0;
    bit   acc_flag = 1'b0;
    op_t  offer;
    op_t  cur;
    int   dir_w = 1;
    logic [63:0] dir_rdata = '0;

    // Values observed on the DUT, used for the literal checks.
    logic [63:0] cap_addr, cap_wdata, cap_wb_data;
    logic [7:0]  cap_wstrb;
    logic        cap_we, cap_wb_wen, cap_mis;
    logic [4:0]  cap_wb_rd;
    int          cap_wb_cyc;
    bit          saw_req, saw_wb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic bit model_mis(input op_t o);
`ifdef LSU_MISALIGN_CHECK_EN
        int nb;
        int offs;
        nb   = 1 << o.size;
        offs = int'(o.addr[2:0]);
        return (o.ld || o.st) && ((offs % nb) != 0);
`else
        return (o.ld && o.st);   // never true: misaligned ops are issued as-is
`endif
    endfunction

    // Byte-by-byte view of a load: gather the bytes present in the dword,
    // then fill the upper bytes with the sign (or zero).
    function automatic logic [63:0] model_load(input op_t o, input logic [63:0] rdata);
        logic [63:0] v;
        int nb;
        int offs;
        logic sign;
        v    = '0;
        nb   = 1 << o.size;
        offs = int'(o.addr[2:0]);
        for (int i = 0; i < nb; i++) begin
            if (offs + i < 8) v[8*i +: 8] = rdata[8*(offs+i) +: 8];
        end
        sign = v[8*nb-1];
        if (!o.uns && sign) begin
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic logic [63:0] model_wdata(input op_t o);
        logic [63:0] v;
        int offs;
        v    = '0;
        offs = int'(o.addr[2:0]);
        for (int i = 0; i < 8; i++) begin
            if (i >= offs) v[8*i +: 8] = o.sdata[8*(i-offs) +: 8];
        end
        return v;
    endfunction

    function automatic logic [7:0] model_wstrb(input op_t o);
        logic [7:0] s;
        int nb;
        int offs;
        s    = '0;
        nb   = 1 << o.size;
        offs = int'(o.addr[2:0]);
        for (int i = 0; i < nb; i++) begin
            if (offs + i < 8) s[offs+i] = 1'b1;
        end
        return s;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int kind;
        kind    = $urandom_range(0, 2);
        o.ld    = (kind == 1);
        o.st    = (kind == 2);
        o.size  = 2'($urandom_range(0, 3));
        o.uns   = 1'($urandom_range(0, 1));
        o.addr  = rand64();
        o.sdata = rand64();
        o.rd    = 5'($urandom_range(0, 31));
        o.wen   = o.st ? 1'b0 : 1'($urandom_range(0, 1));
        o.rdata = '0;
        o.mis   = 1'b0;
        o.w     = 1;
        return o;
    endfunction

    // Compares every DUT output that is meaningful this cycle.
    task automatic compare(input bit exp_ready, input bit exp_req, input bit exp_wb);
        check("ex_ready", 64'(ex_ready), 64'(exp_ready));
        check("mem_req", 64'(mem_req), 64'(exp_req));
        check("wb_valid", 64'(wb_valid), 64'(exp_wb));
        check("misalign_err", 64'(misalign_err), 64'(exp_wb && cur.mis));
        if (exp_req) begin
            check("mem_addr", mem_addr, {cur.addr[63:3], 3'b000});
            check("mem_we", 64'(mem_we), 64'(cur.st));
            if (cur.st) begin
                check("mem_wdata", mem_wdata, model_wdata(cur));
                check("mem_wstrb", 64'(mem_wstrb), 64'(model_wstrb(cur)));
            end
        end
        if (exp_wb) begin
            check("wb_rd_addr", 64'(wb_rd_addr), 64'(cur.rd));
            check("wb_rd_wen", 64'(wb_rd_wen), 64'(cur.wen && !cur.mis));
            if (!cur.ld && !cur.st)
                check("wb_data_alu", wb_data, cur.addr);
            else if (cur.ld && !cur.mis)
                check("wb_data_load", wb_data, model_load(cur, cur.rdata));
        end
        if (mem_req) begin
            saw_req   = 1'b1;
            cap_addr  = mem_addr;
            cap_we    = mem_we;
            cap_wdata = mem_wdata;
            cap_wstrb = mem_wstrb;
        end
        if (wb_valid) begin
            saw_wb      = 1'b1;
            cap_wb_data = wb_data;
            cap_wb_rd   = wb_rd_addr;
            cap_wb_wen  = wb_rd_wen;
            cap_mis     = misalign_err;
            cap_wb_cyc  = cyc;
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare outputs.
    task automatic step();
        bit exp_ready;
        bit exp_req;
        bit exp_wb;
        @(posedge clk);
        #1;
        cyc++;
        acc_flag = 1'b0;
        if (prev_rst) inflight = 1'b0;
        if (inflight && cyc > wb_cyc_exp) inflight = 1'b0;

        if (rand_mode) begin
            rst_drive   = ($urandom_range(0, 299) == 0);
            offer_valid = ($urandom_range(0, 3) != 0);
            offer       = rand_op();
        end
        rst          = rst_drive;
        ex_valid     = offer_valid;
        is_load      = offer.ld;
        is_store     = offer.st;
        mem_size     = offer.size;
        mem_unsigned = offer.uns;
        alu_output   = offer.addr;
        store_data   = offer.sdata;
        rd_addr      = offer.rd;
        rd_wen       = offer.wen;

        exp_ready = !rst_drive && !inflight;
        if (offer_valid && exp_ready) begin
            cur     = offer;
            cur.mis = model_mis(offer);
            cur.w   = rand_mode ? $urandom_range(1, 4) : dir_w;
            cur.rdata = rand_mode ? rand64() : dir_rdata;
            acc_cyc = cyc;
            wb_cyc_exp = ((cur.ld || cur.st) && !cur.mis) ? cyc + cur.w + 1 : cyc + 1;
            inflight = 1'b1;
            acc_flag = 1'b1;
        end

        exp_req = inflight && (cur.ld || cur.st) && !cur.mis &&
                  (acc_cyc < cyc) && (cyc <= acc_cyc + cur.w);
        exp_wb  = inflight && (cyc == wb_cyc_exp);

        if (exp_req && cyc == acc_cyc + cur.w) begin
            mem_ack   = 1'b1;
            mem_rdata = cur.rdata;
        end else begin
            // Acks outside a request must be ignored by the DUT.
            mem_ack   = !exp_req && ($urandom_range(0, 2) == 0);
            mem_rdata = rand64();
        end
        prev_rst = rst_drive;

        @(negedge clk);
        compare(exp_ready, exp_req, exp_wb);
    endtask

    task automatic run_op(input bit ld, input bit st, input logic [1:0] size, input bit uns,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [4:0] rd, input bit wen, input int w,
                          input logic [63:0] rdata);
        int n;
        offer.ld = ld; offer.st = st; offer.size = size; offer.uns = uns;
        offer.addr = addr; offer.sdata = sdata; offer.rd = rd; offer.wen = wen;
        offer.rdata = '0; offer.mis = 1'b0; offer.w = 1;
        dir_w = w;
        dir_rdata = rdata;
        saw_req = 1'b0;
        saw_wb = 1'b0;
        offer_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc_flag && n < 10);
        check("accept", 64'(acc_flag), 64'd1);
        offer_valid = 1'b0;
        n = 0;
        while (inflight && n < 20) begin
            step();
            n++;
        end
        check("complete", 64'(inflight), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        offer = rand_op();
        offer.ld = 1'b0; offer.st = 1'b0; offer.addr = '0; offer.sdata = '0;
        offer.wen = 1'b0; offer.rd = 5'd0; offer.size = 2'd0; offer.uns = 1'b0;

        // Reset, then every output must read 0 except ex_ready.
        rst_drive = 1'b1;
        repeat (3) step();
        rst_drive = 1'b0;
        step();
        check("rst_ex_ready", 64'(ex_ready), 64'd1);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_rd_addr", 64'(wb_rd_addr), 64'd0);
        check("rst_wb_rd_wen", 64'(wb_rd_wen), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);

        // Non-memory pass-through.
        run_op(1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, 64'd0, 5'd5, 1'b1, 1, 64'd0);
        check("pt_wb_data", cap_wb_data, 64'h1234);
        check("pt_wb_rd", 64'(cap_wb_rd), 64'd5);
        check("pt_wb_wen", 64'(cap_wb_wen), 64'd1);
        check("pt_latency", 64'(cap_wb_cyc - acc_cyc), 64'd1);
        check("pt_no_req", 64'(saw_req), 64'd0);

        // Signed and unsigned byte load, ack after 3 REQ cycles.
        run_op(1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'd0, 5'd7, 1'b1, 3, 64'h00000000_80000000);
        check("lb_mem_addr", cap_addr, 64'h1000);
        check("lb_mem_we", 64'(cap_we), 64'd0);
        check("lb_wb_data", cap_wb_data, 64'hFFFFFFFF_FFFFFF80);
        check("lb_latency", 64'(cap_wb_cyc - acc_cyc), 64'd4);
        run_op(1'b1, 1'b0, 2'd0, 1'b1, 64'h1003, 64'd0, 5'd7, 1'b1, 3, 64'h00000000_80000000);
        check("lbu_wb_data", cap_wb_data, 64'h80);

        // Half store in the top lanes.
        run_op(1'b0, 1'b1, 2'd1, 1'b0, 64'h2006, 64'hBEEF, 5'd3, 1'b0, 2, 64'd0);
        check("sh_mem_we", 64'(cap_we), 64'd1);
        check("sh_mem_wstrb", 64'(cap_wstrb), 64'hC0);
        check("sh_mem_wdata", cap_wdata, 64'hBEEF0000_00000000);
        check("sh_mem_addr", cap_addr, 64'h2000);
        check("sh_wb_wen", 64'(cap_wb_wen), 64'd0);

        // Word load with ack in the first REQ cycle.
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h10, 64'd0, 5'd9, 1'b1, 1, 64'h00000000_7FFFFFFF);
        check("lw_wb_data", cap_wb_data, 64'h7FFFFFFF);
        check("lw_latency", 64'(cap_wb_cyc - acc_cyc), 64'd2);

`ifdef LSU_MISALIGN_CHECK_EN
        // Misaligned word: no request, error pulse with the writeback.
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h3002, 64'd0, 5'd4, 1'b1, 2, 64'd0);
        check("mis_no_req", 64'(saw_req), 64'd0);
        check("mis_err", 64'(cap_mis), 64'd1);
        check("mis_wb_wen", 64'(cap_wb_wen), 64'd0);
        check("mis_latency", 64'(cap_wb_cyc - acc_cyc), 64'd1);
`else
        // Misaligned dword issued as-is: only the top three lanes survive.
        run_op(1'b0, 1'b1, 2'd3, 1'b0, 64'h3005, 64'h11223344_55667788, 5'd0, 1'b0, 1, 64'd0);
        check("mis_wstrb", 64'(cap_wstrb), 64'hE0);
        check("mis_wdata", cap_wdata, 64'h66778800_00000000);
        check("mis_err", 64'(cap_mis), 64'd0);
`endif

        // Reset in the second REQ cycle abandons the op.
        begin
            int n;
            offer.ld = 1'b1; offer.st = 1'b0; offer.size = 2'd3; offer.uns = 1'b0;
            offer.addr = 64'h4000; offer.rd = 5'd2; offer.wen = 1'b1;
            dir_w = 6;
            dir_rdata = 64'hDEAD_BEEF;
            offer_valid = 1'b1;
            n = 0;
            do begin
                step();
                n++;
            end while (!acc_flag && n < 10);
            check("rr_accept", 64'(acc_flag), 64'd1);
            offer_valid = 1'b0;
            step();
            rst_drive = 1'b1;
            step();
            check("rr_req_before", 64'(mem_req), 64'd1);
            rst_drive = 1'b0;
            saw_wb = 1'b0;
            step();
            check("rr_req_dropped", 64'(mem_req), 64'd0);
            check("rr_ready", 64'(ex_ready), 64'd1);
            repeat (8) step();
            check("rr_no_wb", 64'(saw_wb), 64'd0);
        end

        // Randomized traffic with spurious acks and occasional resets.
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        rst_drive = 1'b0;
        offer_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (inflight && n < 20) begin
                step();
                n++;
            end
            check("drain", 64'(inflight), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
